// File: rtl/lockin_pkg.sv
// rtl/lockin_pkg.sv - shared state encoding, reference mean and width helpers for the lock-in
package lockin_pkg;

  typedef enum logic [2:0] {
    S_CLEAN,
    S_IDLE,
    S_REF,
    S_RD,
    S_MUL,
    S_ACC,
    S_ADV
  } state_t;

  // Offset-binary midpoint of the 16-bit reference tables.
  localparam int REF_MEAN = 32768;

  // Address/index width that never collapses to zero bits.
  function automatic int clog2w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Accumulator width: full product plus growth for N*M terms.
  function automatic int q_out_w(input int q_in, input int q_ref, input int n, input int m);
    return q_in + q_ref + $clog2(n * m);
  endfunction

endpackage

// File: rtl/lockin_multichannel_if.sv
// rtl/lockin_multichannel_if.sv - input sample beat handshake (all channels per beat)
interface lockin_multichannel_if #(
  parameter int CHANNELS = 8,
  parameter int Q_IN     = 24
);
  logic [CHANNELS*Q_IN-1:0] x_data;
  logic                     x_valid;
  logic                     x_ready;

  modport master (output x_data, output x_valid, input x_ready);
  modport slave  (input x_data, input x_valid, output x_ready);
endinterface

// File: rtl/lockin_ref_lut.sv
// rtl/lockin_ref_lut.sv - sine/cosine reference ROM with registered, centred and scaled read
module lockin_ref_lut
  import lockin_pkg::*;
#(
  parameter int LUT_DEPTH = 2048,
  parameter int M         = 16,
  parameter int Q_REF     = 16
) (
  input  logic                    clk,
  input  logic [clog2w(M)-1:0]    idx_ref,
  output logic signed [Q_REF-1:0] ref_sin,
  output logic signed [Q_REF-1:0] ref_cos
);
  localparam int AW   = clog2w(LUT_DEPTH);
  localparam int STEP = LUT_DEPTH / M;

  // Offset-binary sine table entry; exact at the quarter-period points.
  function automatic logic [15:0] sine_raw(input int k);
    longint h, r, a, v;
    h = longint'(LUT_DEPTH / 2);
    r = longint'(k) % h;
    a = r * (h - r);
    v = (longint'(32767) * 16 * a) / (5 * h * h - 4 * a);
    return (longint'(k) < h) ? 16'(longint'(REF_MEAN) + v) : 16'(longint'(REF_MEAN) - v);
  endfunction

  logic [15:0]        sin_rom [LUT_DEPTH];
  logic [15:0]        cos_rom [LUT_DEPTH];
  logic [AW-1:0]      addr;
  logic signed [16:0] c_sin;
  logic signed [16:0] c_cos;

  for (genvar i = 0; i < LUT_DEPTH; i++) begin : g_rom
    assign sin_rom[i] = sine_raw(i);
    assign cos_rom[i] = sine_raw((i + LUT_DEPTH / 4) % LUT_DEPTH);
  end

  assign addr  = AW'(int'(idx_ref) * STEP);
  assign c_sin = $signed({1'b0, sin_rom[addr]}) - 17'(REF_MEAN);
  assign c_cos = $signed({1'b0, cos_rom[addr]}) - 17'(REF_MEAN);

  // One-cycle registered ROM read, centred about zero and scaled to Q_REF bits.
  always_ff @(posedge clk) begin
    ref_sin <= Q_REF'(c_sin >>> (16 - Q_REF));
    ref_cos <= Q_REF'(c_cos >>> (16 - Q_REF));
  end

endmodule

// File: rtl/lockin_multichannel.sv
// rtl/lockin_multichannel.sv - multi-channel sliding-window lock-in; LOCKIN_DECIM_EN emits one burst per full window
module lockin_multichannel
  import lockin_pkg::*;
#(
  parameter int CHANNELS  = 8,
  parameter int Q_IN      = 24,
  parameter int Q_REF     = 16,
  parameter int M         = 16,
  parameter int N         = 16,
  parameter int LUT_DEPTH = 2048
) (
  input  logic                                         clk,
  input  logic                                         reset_n,
  input  logic                                         sync_clear,
  lockin_multichannel_if.slave                         x_if,
  output logic [clog2w(CHANNELS)-1:0]                  out_ch,
  output logic signed [q_out_w(Q_IN, Q_REF, N, M)-1:0] out_fase,
  output logic signed [q_out_w(Q_IN, Q_REF, N, M)-1:0] out_cuad,
  output logic                                         out_valid
);
  localparam int NM        = N * M;
  localparam int Q_OUT     = q_out_w(Q_IN, Q_REF, N, M);
  localparam int PW        = Q_IN + Q_REF;
  localparam int BUF_DEPTH = CHANNELS * NM;
  localparam int CH_W      = clog2w(CHANNELS);
  localparam int SIG_W     = clog2w(NM);
  localparam int REF_W     = clog2w(M);
  localparam int BUF_AW    = clog2w(BUF_DEPTH);

  state_t                   state;
  logic [CH_W-1:0]          ch;
  logic [SIG_W-1:0]         idx_sig;
  logic [REF_W-1:0]         idx_ref;
  logic [BUF_AW-1:0]        clean_cnt;
  logic                     x_ready_q;
  logic [CHANNELS*Q_IN-1:0] x_lat;
  logic signed [Q_REF-1:0]  ref_sin, ref_cos;
  logic signed [Q_IN-1:0]   x_sel;
  logic signed [PW-1:0]     mul_sin, mul_cos;
  logic signed [Q_OUT-1:0]  prod_fase, prod_cuad, old_fase, old_cuad, new_fase, new_cuad;
  logic signed [Q_OUT-1:0]  acc_fase [CHANNELS];
  logic signed [Q_OUT-1:0]  acc_cuad [CHANNELS];
  logic signed [Q_OUT-1:0]  buf_fase [BUF_DEPTH];
  logic signed [Q_OUT-1:0]  buf_cuad [BUF_DEPTH];
  logic [BUF_AW-1:0]        buf_addr, wr_addr;
  logic                     buf_we;
  logic                     emit;

  lockin_ref_lut #(
    .LUT_DEPTH (LUT_DEPTH),
    .M         (M),
    .Q_REF     (Q_REF)
  ) u_ref_lut (
    .clk     (clk),
    .idx_ref (idx_ref),
    .ref_sin (ref_sin),
    .ref_cos (ref_cos)
  );

  assign x_if.x_ready = x_ready_q;
  assign x_sel        = $signed(x_lat[int'(ch)*Q_IN +: Q_IN]);
  assign mul_sin      = PW'(x_sel) * PW'(ref_sin);
  assign mul_cos      = PW'(x_sel) * PW'(ref_cos);
  assign buf_addr     = BUF_AW'(int'(ch) * NM + int'(idx_sig));
  assign buf_we       = (state == S_CLEAN) || (state == S_ACC);
  assign wr_addr      = (state == S_CLEAN) ? clean_cnt : buf_addr;
  assign new_fase     = acc_fase[ch] - old_fase + prod_fase;
  assign new_cuad     = acc_cuad[ch] - old_cuad + prod_cuad;

`ifdef LOCKIN_DECIM_EN
  assign emit = (idx_sig == SIG_W'(NM - 1));
`else
  assign emit = 1'b1;
`endif

  // Window buffers: CLEAN zeroes one word per cycle, ACC stores the new product, RD fetches the oldest.
  always_ff @(posedge clk) begin
    if (buf_we) begin
      buf_fase[wr_addr] <= (state == S_CLEAN) ? '0 : prod_fase;
      buf_cuad[wr_addr] <= (state == S_CLEAN) ? '0 : prod_cuad;
    end
    if (state == S_RD) begin
      old_fase <= buf_fase[buf_addr];
      old_cuad <= buf_cuad[buf_addr];
    end
  end

  // Beat sequencer: accept, per-channel read/multiply/accumulate, advance indices, registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_CLEAN;
      ch        <= '0;
      idx_sig   <= '0;
      idx_ref   <= '0;
      clean_cnt <= '0;
      x_ready_q <= 1'b0;
      x_lat     <= '0;
      prod_fase <= '0;
      prod_cuad <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        acc_fase[i] <= '0;
        acc_cuad[i] <= '0;
      end
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_fase  <= '0;
      out_cuad  <= '0;
    end else begin
      out_valid <= 1'b0;
      if (sync_clear) begin
        state     <= S_CLEAN;
        ch        <= '0;
        idx_sig   <= '0;
        idx_ref   <= '0;
        clean_cnt <= '0;
        x_ready_q <= 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
          acc_fase[i] <= '0;
          acc_cuad[i] <= '0;
        end
      end else begin
        case (state)
          S_CLEAN: begin
            if (clean_cnt == BUF_AW'(BUF_DEPTH - 1)) begin
              clean_cnt <= '0;
              x_ready_q <= 1'b1;
              state     <= S_IDLE;
            end else begin
              clean_cnt <= clean_cnt + 1'b1;
            end
          end
          S_IDLE: begin
            if (x_if.x_valid && x_ready_q) begin
              x_lat     <= x_if.x_data;
              x_ready_q <= 1'b0;
              state     <= S_REF;
            end
          end
          S_REF: begin
            ch    <= '0;
            state <= S_RD;
          end
          S_RD: state <= S_MUL;
          S_MUL: begin
            prod_fase <= Q_OUT'(mul_sin);
            prod_cuad <= Q_OUT'(mul_cos);
            state     <= S_ACC;
          end
          S_ACC: begin
            acc_fase[ch] <= new_fase;
            acc_cuad[ch] <= new_cuad;
            out_valid    <= emit;
            out_ch       <= ch;
            out_fase     <= new_fase;
            out_cuad     <= new_cuad;
            if (ch == CH_W'(CHANNELS - 1)) begin
              state <= S_ADV;
            end else begin
              ch    <= ch + 1'b1;
              state <= S_RD;
            end
          end
          S_ADV: begin
            idx_sig   <= (idx_sig == SIG_W'(NM - 1)) ? '0 : idx_sig + 1'b1;
            idx_ref   <= (idx_ref == REF_W'(M - 1)) ? '0 : idx_ref + 1'b1;
            x_ready_q <= 1'b1;
            state     <= S_IDLE;
          end
          default: state <= S_CLEAN;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lockin_multichannel.sv
// tb/tb_lockin_multichannel.sv - scoreboard bench for the multi-channel lock-in (small build)
module tb_lockin_multichannel;
  localparam int CHANNELS  = 2;
  localparam int Q_IN      = 16;
  localparam int Q_REF     = 16;
  localparam int M         = 4;
  localparam int N         = 2;
  localparam int LUT_DEPTH = 2048;
  localparam int NM        = N * M;
  localparam int Q_OUT     = Q_IN + Q_REF + $clog2(NM);

  localparam longint SIN_C [M] = '{0, 32767, 0, -32767};
  localparam longint COS_C [M] = '{32767, 0, -32767, 0};

  typedef struct {
    int     ch;
    longint fase;
    longint cuad;
  } exp_t;

  logic                    clk = 1'b0;
  logic                    reset_n = 1'b1;
  logic                    sync_clear = 1'b0;
  logic [0:0]              out_ch;
  logic signed [Q_OUT-1:0] out_fase;
  logic signed [Q_OUT-1:0] out_cuad;
  logic                    out_valid;

  lockin_multichannel_if #(.CHANNELS(CHANNELS), .Q_IN(Q_IN)) x_if ();

  lockin_multichannel #(
    .CHANNELS  (CHANNELS),
    .Q_IN      (Q_IN),
    .Q_REF     (Q_REF),
    .M         (M),
    .N         (N),
    .LUT_DEPTH (LUT_DEPTH)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .sync_clear (sync_clear),
    .x_if       (x_if),
    .out_ch     (out_ch),
    .out_fase   (out_fase),
    .out_cuad   (out_cuad),
    .out_valid  (out_valid)
  );

  always #5 clk = ~clk;

  int     vectors = 0;
  int     miscompares = 0;
  exp_t   sb [$];
  longint hist_f [CHANNELS][NM];
  longint hist_c [CHANNELS][NM];
  longint m_acc_f [CHANNELS];
  longint m_acc_c [CHANNELS];
  longint last_f [CHANNELS];
  longint last_c [CHANNELS];
  longint ch0_fase [$];
  int     acc_t [$];
  int     m_si, m_ri, cyc, last_acc, n_acc, n_out, base;
  bit     push_en;

  task automatic chk(input string tag, input longint got, input longint exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int c = 0; c < CHANNELS; c++) begin
      m_acc_f[c] = 0;
      m_acc_c[c] = 0;
      for (int s = 0; s < NM; s++) begin
        hist_f[c][s] = 0;
        hist_c[c][s] = 0;
      end
    end
    m_si = 0;
    m_ri = 0;
  endtask

  task automatic model_beat(input longint x0, input longint x1);
    longint x, pf, pc;
    exp_t   e;
    for (int c = 0; c < CHANNELS; c++) begin
      x  = (c == 0) ? x0 : x1;
      pf = x * SIN_C[m_ri];
      pc = x * COS_C[m_ri];
      m_acc_f[c] = m_acc_f[c] - hist_f[c][m_si] + pf;
      m_acc_c[c] = m_acc_c[c] - hist_c[c][m_si] + pc;
      hist_f[c][m_si] = pf;
      hist_c[c][m_si] = pc;
      e.ch = c;
      e.fase = m_acc_f[c];
      e.cuad = m_acc_c[c];
`ifdef LOCKIN_DECIM_EN
      if (m_si == NM - 1) sb.push_back(e);
`else
      sb.push_back(e);
`endif
    end
    m_si = (m_si + 1) % NM;
    m_ri = (m_ri + 1) % M;
  endtask

  task automatic check_out();
    exp_t e;
    n_out++;
    chk("sb_nonempty", longint'(sb.size() > 0), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("out_ch", longint'(out_ch), e.ch);
      chk("out_fase", longint'(out_fase), e.fase);
      chk("out_cuad", longint'(out_cuad), e.cuad);
      chk("out_latency", cyc - last_acc, 4 + 3 * e.ch);
      last_f[e.ch] = longint'(out_fase);
      last_c[e.ch] = longint'(out_cuad);
      if (e.ch == 0) ch0_fase.push_back(longint'(out_fase));
    end
  endtask

  task automatic step();
    bit     acc_now;
    longint x0, x1;
    acc_now = x_if.x_valid && x_if.x_ready && !sync_clear && reset_n;
    x0 = longint'($signed(x_if.x_data[15:0]));
    x1 = longint'($signed(x_if.x_data[31:16]));
    @(posedge clk);
    #1;
    cyc++;
    if (acc_now) begin
      n_acc++;
      last_acc = cyc;
      acc_t.push_back(cyc);
      if (push_en) model_beat(x0, x1);
    end
    if (out_valid) check_out();
  endtask

  task automatic send_beat(input longint x0, input longint x1, input bit keep);
    int b, t;
    b = n_acc;
    t = 0;
    x_if.x_data  = {16'(x1), 16'(x0)};
    x_if.x_valid = 1'b1;
    while (n_acc == b && t < 60) begin
      step();
      t++;
    end
    if (!keep) x_if.x_valid = 1'b0;
    chk("beat_accepted", n_acc - b, 1);
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!x_if.x_ready && n < 100) begin
      step();
      n++;
    end
    chk(tag, n, 16);
  endtask

  initial begin
    x_if.x_valid = 1'b0;
    x_if.x_data  = '0;
    push_en = 1'b1;
    cyc = 0; last_acc = 0; n_acc = 0; n_out = 0;
    for (int c = 0; c < CHANNELS; c++) begin
      last_f[c] = -1;
      last_c[c] = -1;
    end
    model_clear();

    #2 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_out_fase", longint'(out_fase), 0);
    chk("rst_out_cuad", longint'(out_cuad), 0);
    chk("rst_out_ch", longint'(out_ch), 0);
    chk("rst_x_ready", longint'(x_if.x_ready), 0);
    @(negedge clk) reset_n = 1'b1;
    wait_ready("clean_cycles_after_reset");
    chk("clean_out_fase", longint'(out_fase), 0);
    chk("clean_out_cuad", longint'(out_cuad), 0);

    // DC on both channels for one full window
    for (int b = 0; b < 8; b++) send_beat(1000, 1000, 1'b0);
    repeat (12) step();
    chk("dc_fase_ch0", last_f[0], 0);
    chk("dc_cuad_ch0", last_c[0], 0);
    chk("dc_fase_ch1", last_f[1], 0);
    chk("dc_cuad_ch1", last_c[1], 0);

    // x_valid held high across three beats
    acc_t.delete();
    base = n_acc;
    x_if.x_data  = {16'(-700), 16'(500)};
    x_if.x_valid = 1'b1;
    for (int t = 0; t < 60 && n_acc < base + 3; t++) step();
    x_if.x_valid = 1'b0;
    chk("held_accepts", n_acc - base, 3);
    if (acc_t.size() >= 3) begin
      chk("accept_interval_1", acc_t[1] - acc_t[0], 9);
      chk("accept_interval_2", acc_t[2] - acc_t[1], 9);
    end
    repeat (10) step();
    chk("sb_drained_handshake", sb.size(), 0);

    // sync_clear while the beat is in MUL
    push_en = 1'b0;
    send_beat(1234, -4321, 1'b0);
    step();
    step();
    sync_clear = 1'b1;
    step();
    sync_clear = 1'b0;
    push_en = 1'b1;
    model_clear();
    wait_ready("clean_cycles_after_abort");

    // sync_clear wins over x_valid in IDLE
    base = n_acc;
    x_if.x_valid = 1'b1;
    sync_clear   = 1'b1;
    step();
    sync_clear   = 1'b0;
    x_if.x_valid = 1'b0;
    chk("clear_blocks_accept", n_acc - base, 0);
    wait_ready("clean_cycles_after_idle_clear");
    model_clear();

    // ch0 matched to the sine reference, ch1 silent, two full windows
    ch0_fase.delete();
    n_out = 0;
    for (int b = 0; b < 16; b++) send_beat((1000 * SIN_C[m_ri]) / 32767, 0, 1'b0);
    repeat (12) step();
    for (int i = 1; i < ch0_fase.size(); i++)
      chk("ch0_monotonic", longint'(ch0_fase[i] >= ch0_fase[i-1]), 1);
    chk("matched_steady_ch0", last_f[0], 131068000);
    chk("matched_ch1_fase", last_f[1], 0);
    chk("matched_ch1_cuad", last_c[1], 0);
`ifdef LOCKIN_DECIM_EN
    chk("out_valid_count", n_out, 4);
`else
    chk("out_valid_count", n_out, 32);
`endif
    chk("sb_drained_end", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
